fp_addsub_issue: RTL
====================

// Module: fp_addsub_issue
// PURPOSE
//  Sequential issue/retire stage wrapped around the combinational FP add/sub datapath.
//  Accepts two packed IEEE-754 single operands plus an add/sub opcode over a valid/ready handshake.
//  Unpacks them into sign/exponent/significand fields and holds them stable while the datapath settles.
//  Captures fp_out/error into a result register, presents it downstream over valid/ready, and keeps sticky error flags.
// PARAMETERS
//  SETTLE_CYCLES  2  cycles the datapath inputs are held before fp_out/error are sampled (legal 1..15)
// PORTS
//  clk         in   1   single clock, all state on rising edge
//  rst_n       in   1   asynchronous, active-low reset
//  in_valid    in   1   upstream operand pair valid
//  in_ready    out  1   stage can accept an operand pair this cycle
//  op_a        in   32  operand 1, packed {sign,exp[7:0],sig[22:0]}
//  op_b        in   32  operand 2, same packing
//  in_opcode   in   1   0: op_a+op_b; 1: op_a-op_b
//  out_valid   out  1   result register holds an unconsumed result
//  out_ready   in   1   downstream accepts result this cycle
//  result      out  32  captured fp_out
//  result_err  out  3   captured error code for this result
//  sticky_err  out  3   OR of all captured error codes since reset/clear
//  sticky_clr  in   1   clear sticky_err (one-cycle pulse)
//  busy        out  1   state != IDLE
//  sign1,sign2 out  1   to datapath: operand signs (op_x[31])
//  exp1,exp2   out  8   to datapath: operand exponents (op_x[30:23])
//  sig1,sig2   out  23  to datapath: operand fractions (op_x[22:0])
//  opcode      out  1   to datapath: latched in_opcode
//  fp_out      in   32  from datapath: result
//  error       in   3   from datapath: error code, treated as opaque bits
// BEHAVIOUR
//  Reset (rst_n=0, async): state=IDLE, operand/opcode regs=0, result=0, result_err=0,
//   sticky_err=0, counter=0, out_valid=0, busy=0; in_ready=1 once rst_n deasserts.
//  FSM states IDLE, EXEC, DONE.
//  in_ready = (state==IDLE) | (state==DONE & out_ready). Accept = in_valid & in_ready.
//  Accept at edge N: latch op_a, op_b, in_opcode into operand regs; counter<=SETTLE_CYCLES-1;
//   state<=EXEC. Datapath outputs are driven only from operand regs, stable through EXEC and DONE.
//  EXEC: if counter!=0, counter<=counter-1; if counter==0, capture at that edge:
//   result<=fp_out, result_err<=error, state<=DONE. Capture edge = N+SETTLE_CYCLES.
//   out_valid rises the cycle after capture.
//  DONE: out_valid=1, result/result_err held until out_valid & out_ready.
//   Handshake with no accept -> IDLE. Handshake with accept (back-to-back) -> EXEC,
//   new operands latched on the same edge; out_valid=0 next cycle.
//  out_ready ignored outside DONE; in_valid ignored while in_ready=0 (operands not sampled).
//  sticky_err_next = (sticky_clr ? 3'b0 : sticky_err) | (capture ? error : 3'b0);
//   clear and capture in the same cycle leave exactly the new error bits set.
//  Latency accept->out_valid: SETTLE_CYCLES+1 cycles. Throughput: one op per SETTLE_CYCLES+1
//   cycles with out_ready held high.
//  No opcode decode or arithmetic in this block; fields pass through bit-exact.
//  Reset mid-EXEC or mid-DONE discards the in-flight op; no out_valid follows.
// TESTING
//  1) op_a=0x3F800000, op_b=0x3F800000, opcode=0, out_ready=1 -> result=0x40000000,
//     result_err=0, out_valid at accept+3 (SETTLE_CYCLES=2).
//  2) op_a=0x40400000, op_b=0x3F800000, opcode=1 -> result=0x40000000;
//     exp1=0x80, sig1=0x400000 held stable through EXEC.
//  3) Backpressure: out_ready=0 for 10 cycles in DONE -> result stable, in_ready=0,
//     second in_valid not accepted until the out_ready cycle, then accepted back-to-back.
//  4) Stub datapath error=3'b010 then 3'b100 -> sticky_err=3'b110; sticky_clr on the
//     capture edge of error=3'b001 -> sticky_err=3'b001.
//  5) rst_n low one cycle mid-EXEC -> all outputs 0, busy=0, no out_valid afterwards,
//     next op completes normally.
//  6) SETTLE_CYCLES=1 and 15 -> capture at accept+1 / accept+15; out_valid one cycle later.

Source files
------------

// File: rtl/fp_addsub_issue.sv
// fp_addsub_issue: issue/retire stage around the combinational FP add/sub datapath.
// Upstream: in_valid/in_ready, op_a, op_b, in_opcode.
// Downstream: out_valid/out_ready, result, result_err.
// Status: busy, sticky_err (cleared by sticky_clr).
// Datapath: sign/exp/sig/opcode out, fp_out/error in.
module fp_addsub_issue #(
    parameter int unsigned SETTLE_CYCLES = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] op_a,
    input  logic [31:0] op_b,
    input  logic        in_opcode,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] result,
    output logic [2:0]  result_err,
    output logic [2:0]  sticky_err,
    input  logic        sticky_clr,
    output logic        busy,
    output logic        sign1,
    output logic        sign2,
    output logic [7:0]  exp1,
    output logic [7:0]  exp2,
    output logic [22:0] sig1,
    output logic [22:0] sig2,
    output logic        opcode,
    input  logic [31:0] fp_out,
    input  logic [2:0]  error
);

    typedef enum logic [1:0] {
        IDLE,
        EXEC,
        DONE
    } state_t;

    localparam logic [3:0] CNT_INIT = 4'(SETTLE_CYCLES - 1);

    state_t      state;
    logic [3:0]  cnt;
    logic [31:0] a_q;
    logic [31:0] b_q;
    logic        op_q;
    logic        accept;
    logic        capture;

    // Held low in reset so nothing upstream sees a ready during reset.
    assign in_ready = rst_n &
                      ((state == IDLE) |
                       ((state == DONE) & out_ready));
    assign accept   = in_valid & in_ready;
    assign capture  = (state == EXEC) & (cnt == 4'd0);

    // Datapath sees only the operand registers.
    assign sign1  = a_q[31];
    assign exp1   = a_q[30:23];
    assign sig1   = a_q[22:0];
    assign sign2  = b_q[31];
    assign exp2   = b_q[30:23];
    assign sig2   = b_q[22:0];
    assign opcode = op_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            cnt        <= 4'd0;
            a_q        <= 32'd0;
            b_q        <= 32'd0;
            op_q       <= 1'b0;
            result     <= 32'd0;
            result_err <= 3'd0;
            sticky_err <= 3'd0;
            out_valid  <= 1'b0;
            busy       <= 1'b0;
        end else begin
            if (accept) begin
                a_q  <= op_a;
                b_q  <= op_b;
                op_q <= in_opcode;
                cnt  <= CNT_INIT;
            end

            unique case (state)
                IDLE: begin
                    if (accept) begin
                        state <= EXEC;
                        busy  <= 1'b1;
                    end
                end
                EXEC: begin
                    if (cnt != 4'd0) begin
                        cnt <= cnt - 4'd1;
                    end else begin
                        result     <= fp_out;
                        result_err <= error;
                        state      <= DONE;
                        out_valid  <= 1'b1;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        if (accept) begin
                            state <= EXEC;
                        end else begin
                            state <= IDLE;
                            busy  <= 1'b0;
                        end
                    end
                end
                default: begin
                    state     <= IDLE;
                    out_valid <= 1'b0;
                    busy      <= 1'b0;
                end
            endcase

            // A clear coinciding with a capture keeps the new bits.
            sticky_err <= (sticky_clr ? 3'd0 : sticky_err) |
                          (capture ? error : 3'd0);
        end
    end

endmodule
